vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/blank timing generator driven by a divided pixel
// strobe. x/y count pixels and lines; hsync/vsync/blank_n are decoded from the
// next x/y so they line up with the counters, then optionally delayed by a
// small pixel-advanced pipeline for downstream pixel-data latency.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   PIPE_DLY = 0,
    localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    output logic                       vga_clk,
    output logic                       pix_en,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       blank_n,
    output logic                       sync_n,
    output logic [$clog2(H_TOTAL)-1:0] x,
    output logic [$clog2(V_TOTAL)-1:0] y,
    output logic                       active,
    output logic                       line_start,
    output logic                       frame_start,
    output logic [7:0]                 frame_cnt
);

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CLK_DIV);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

    // Horizontal sync window decode for a given column.
    function automatic logic h_sync_on(input logic [XW-1:0] xv);
        int xi;
        xi = int'(xv);
        return (xi >= H_ACTIVE + H_FP) && (xi < H_ACTIVE + H_FP + H_SYNC);
    endfunction

    // Vertical sync window decode for a given line.
    function automatic logic v_sync_on(input logic [YW-1:0] yv);
        int yi;
        yi = int'(yv);
        return (yi >= V_ACTIVE + V_FP) && (yi < V_ACTIVE + V_FP + V_SYNC);
    endfunction

    // Visible-area decode for a given column/line.
    function automatic logic area_on(input logic [XW-1:0] xv, input logic [YW-1:0] yv);
        return (int'(xv) < H_ACTIVE) && (int'(yv) < V_ACTIVE);
    endfunction

    logic [DW-1:0]     divcnt_r;
    logic [DW-1:0]     divcnt_nxt_s;
    logic [XW-1:0]     x_r;
    logic [XW-1:0]     x_nxt_s;
    logic [YW-1:0]     y_r;
    logic [YW-1:0]     y_nxt_s;
    logic              line_wrap_s;
    logic              frame_wrap_s;
    logic              pix_en_r;
    logic              vga_clk_r;
    logic              line_start_r;
    logic              frame_start_r;
    logic              active_r;
    logic [7:0]        frame_cnt_r;
    logic [PIPE_DLY:0] hs_pipe_r;
    logic [PIPE_DLY:0] vs_pipe_r;
    logic [PIPE_DLY:0] bl_pipe_r;

    // Next divider count and next raster position, plus the wrap events.
    always_comb begin
        divcnt_nxt_s = '0;
        x_nxt_s      = x_r;
        y_nxt_s      = y_r;
        line_wrap_s  = 1'b0;
        frame_wrap_s = 1'b0;
        if (!enable) begin
            x_nxt_s = '0;
            y_nxt_s = '0;
        end else begin
            if (divcnt_r == DIV_LAST) begin
                divcnt_nxt_s = '0;
            end else begin
                divcnt_nxt_s = divcnt_r + DW'(1);
            end
            if (pix_en_r) begin
                if (x_r == X_LAST) begin
                    x_nxt_s     = '0;
                    line_wrap_s = 1'b1;
                    if (y_r == Y_LAST) begin
                        y_nxt_s      = '0;
                        frame_wrap_s = 1'b1;
                    end else begin
                        y_nxt_s = y_r + YW'(1);
                    end
                end else begin
                    x_nxt_s = x_r + XW'(1);
                end
            end else begin
                x_nxt_s = x_r;
                y_nxt_s = y_r;
            end
        end
    end

    // Divider, pixel strobe, raster counters, start pulses and frame counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            divcnt_r      <= '0;
            x_r           <= '0;
            y_r           <= '0;
            pix_en_r      <= 1'b0;
            vga_clk_r     <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            active_r      <= area_on('0, '0);
            frame_cnt_r   <= 8'd0;
        end else if (!enable) begin
            divcnt_r      <= '0;
            x_r           <= '0;
            y_r           <= '0;
            pix_en_r      <= 1'b0;
            vga_clk_r     <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            active_r      <= area_on('0, '0);
        end else begin
            divcnt_r      <= divcnt_nxt_s;
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            pix_en_r      <= (divcnt_r == DIV_LAST);
            vga_clk_r     <= (divcnt_nxt_s >= DIV_HALF);
            line_start_r  <= line_wrap_s;
            frame_start_r <= frame_wrap_s;
            active_r      <= area_on(x_nxt_s, y_nxt_s);
            if (frame_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Sync/blank decode aligned with x/y, then shifted once per pixel strobe.
    always_ff @(posedge clk) begin
        if (!reset_n || !enable) begin
            hs_pipe_r <= {(PIPE_DLY + 1){~HS_POL}};
            vs_pipe_r <= {(PIPE_DLY + 1){~VS_POL}};
            bl_pipe_r <= '0;
        end else begin
            hs_pipe_r[0] <= h_sync_on(x_nxt_s) ? HS_POL : ~HS_POL;
            vs_pipe_r[0] <= v_sync_on(y_nxt_s) ? VS_POL : ~VS_POL;
            bl_pipe_r[0] <= area_on(x_nxt_s, y_nxt_s);
            if (pix_en_r) begin
                for (int k = 1; k <= PIPE_DLY; k++) begin
                    hs_pipe_r[k] <= hs_pipe_r[k-1];
                    vs_pipe_r[k] <= vs_pipe_r[k-1];
                    bl_pipe_r[k] <= bl_pipe_r[k-1];
                end
            end
        end
    end

    assign vga_clk     = vga_clk_r;
    assign pix_en      = pix_en_r;
    assign hsync       = hs_pipe_r[PIPE_DLY];
    assign vsync       = vs_pipe_r[PIPE_DLY];
    assign blank_n     = bl_pipe_r[PIPE_DLY];
    assign sync_n      = 1'b0;
    assign x           = x_r;
    assign y           = y_r;
    assign active      = active_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_cnt   = frame_cnt_r;

endmodule
